// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared types and sizing constants for the MAC datapath
//               (mac_mult_seq, mac_idx_counter, mac_stop_accum).
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } mac_state_t;

    localparam int C_DEF_M      = 4;
    localparam int C_DEF_K      = 4;
    localparam int C_DEF_N      = 4;
    localparam int C_DEF_DATA_W = 32;

    localparam int C_ROW_A_W = $clog2(C_DEF_M);
    localparam int C_K_W     = $clog2(C_DEF_K);
    localparam int C_COL_B_W = $clog2(C_DEF_N);
    localparam int C_PROD_W  = 2 * C_DEF_DATA_W;

    // Number of cycles spent in DRAIN while the product pipeline empties.
    localparam int C_DRAIN_CYCLES = 2;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_idx_counter.sv
`default_nettype none
// ============================================================================
// Module      : mac_idx_counter
// Description : Nested (i, j, k) index counter; k innermost, then j, then i.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_idx_counter #(
    parameter int M = 4,
    parameter int K = 4,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 advance,
    output logic [$clog2(M)-1:0] i,
    output logic [$clog2(N)-1:0] j,
    output logic [$clog2(K)-1:0] k,
    output logic                 last
);

    localparam int C_IW = $clog2(M);
    localparam int C_JW = $clog2(N);
    localparam int C_KW = $clog2(K);

    localparam logic [C_IW-1:0] C_I_MAX = C_IW'(M - 1);
    localparam logic [C_JW-1:0] C_J_MAX = C_JW'(N - 1);
    localparam logic [C_KW-1:0] C_K_MAX = C_KW'(K - 1);

    logic [C_IW-1:0] r_i;
    logic [C_JW-1:0] r_j;
    logic [C_KW-1:0] r_k;

    logic w_i_max;
    logic w_j_max;
    logic w_k_max;

    assign w_i_max = (r_i == C_I_MAX);
    assign w_j_max = (r_j == C_J_MAX);
    assign w_k_max = (r_k == C_K_MAX);

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (advance) begin
            if (!w_k_max) begin
                r_k <= r_k + C_KW'(1);
            end else begin
                r_k <= '0;
                if (!w_j_max) begin
                    r_j <= r_j + C_JW'(1);
                end else begin
                    r_j <= '0;
                    r_i <= w_i_max ? '0 : r_i + C_IW'(1);
                end
            end
        end
    end

    assign i    = r_i;
    assign j    = r_j;
    assign k    = r_k;
    assign last = w_i_max && w_j_max && w_k_max;

endmodule : mac_idx_counter
`default_nettype wire

// File: rtl/mac_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : mac_mult_seq
// Description : Walks the (i, j, k) space of C = A*B, issues A/B read
//               addresses and emits registered products with aligned indices.
//               Define MAC_MULT_SIGNED_EN for two's-complement operands.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_mult_seq
    import mac_pkg::*;
#(
    parameter int M                      = C_DEF_M,
    parameter int K                      = C_DEF_K,
    parameter int N                      = C_DEF_N,
    parameter int DATA_WIDTH_INIT_MATRIX = C_DEF_DATA_W
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  start,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_out_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_out_b,
    output logic [$clog2(M)-1:0]                  row_addr_a,
    output logic [$clog2(K)-1:0]                  col_addr_a,
    output logic [$clog2(K)-1:0]                  row_addr_b,
    output logic [$clog2(N)-1:0]                  col_addr_b,
    output logic [2*DATA_WIDTH_INIT_MATRIX-1:0]   product_reg,
    output logic [$clog2(M)-1:0]                  matrix_a_row_addr_counter_reg,
    output logic [$clog2(K)-1:0]                  matrix_a_col_addr_counter_reg,
    output logic [$clog2(K)-1:0]                  matrix_b_row_addr_counter_reg,
    output logic [$clog2(N)-1:0]                  matrix_b_col_addr_counter_reg,
    output logic                                  mult_done_reg,
    output logic                                  busy,
    output logic                                  seq_done
);

    localparam int C_DW = DATA_WIDTH_INIT_MATRIX;
    localparam int C_PW = 2 * DATA_WIDTH_INIT_MATRIX;
    localparam int C_IW = $clog2(M);
    localparam int C_JW = $clog2(N);
    localparam int C_KW = $clog2(K);

    mac_state_t r_state;
    mac_state_t w_state_nxt;
    logic       r_drain_cnt;
    logic       r_seq_done;

    logic            w_clear;
    logic            w_advance;
    logic [C_IW-1:0] w_i;
    logic [C_JW-1:0] w_j;
    logic [C_KW-1:0] w_k;
    logic            w_last;

    logic            r_s1_valid;
    logic [C_IW-1:0] r_s1_i;
    logic [C_JW-1:0] r_s1_j;
    logic [C_KW-1:0] r_s1_k;

    logic            r_mult_done;
    logic [C_PW-1:0] r_product;
    logic [C_IW-1:0] r_c_i;
    logic [C_JW-1:0] r_c_j;
    logic [C_KW-1:0] r_c_k;

    logic [C_PW-1:0] w_op_a;
    logic [C_PW-1:0] w_op_b;
    logic [C_PW-1:0] w_product;

    mac_idx_counter #(
        .M (M),
        .K (K),
        .N (N)
    ) u_idx_counter (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (w_clear),
        .advance (w_advance),
        .i       (w_i),
        .j       (w_j),
        .k       (w_k),
        .last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The counter stops on the last index so the addresses hold afterwards.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_clear     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_drain_cnt <= 1'b0;
            r_seq_done  <= 1'b0;
        end else begin
            r_drain_cnt <= (r_state == ST_DRAIN) ? ~r_drain_cnt : 1'b0;
            r_seq_done  <= (r_state == ST_DRAIN) && r_drain_cnt;
        end
    end

    // Stage 1 tracks the address issued this cycle; memory data follows next cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_i     <= '0;
            r_s1_j     <= '0;
            r_s1_k     <= '0;
        end else begin
            r_s1_valid <= (r_state == ST_RUN);
            r_s1_i     <= w_i;
            r_s1_j     <= w_j;
            r_s1_k     <= w_k;
        end
    end

`ifdef MAC_MULT_SIGNED_EN
    assign w_op_a = {{C_DW{data_out_a[C_DW-1]}}, data_out_a};
    assign w_op_b = {{C_DW{data_out_b[C_DW-1]}}, data_out_b};
`else
    assign w_op_a = {{C_DW{1'b0}}, data_out_a};
    assign w_op_b = {{C_DW{1'b0}}, data_out_b};
`endif

    assign w_product = w_op_a * w_op_b;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mult_done <= 1'b0;
            r_product   <= '0;
            r_c_i       <= '0;
            r_c_j       <= '0;
            r_c_k       <= '0;
        end else begin
            r_mult_done <= r_s1_valid;
            if (r_s1_valid) begin
                r_product <= w_product;
                r_c_i     <= r_s1_i;
                r_c_j     <= r_s1_j;
                r_c_k     <= r_s1_k;
            end
        end
    end

    assign row_addr_a                    = w_i;
    assign col_addr_a                    = w_k;
    assign row_addr_b                    = w_k;
    assign col_addr_b                    = w_j;
    assign product_reg                   = r_product;
    assign matrix_a_row_addr_counter_reg = r_c_i;
    assign matrix_a_col_addr_counter_reg = r_c_k;
    assign matrix_b_row_addr_counter_reg = r_c_k;
    assign matrix_b_col_addr_counter_reg = r_c_j;
    assign mult_done_reg                 = r_mult_done;
    assign busy                          = (r_state != ST_IDLE);
    assign seq_done                      = r_seq_done;

endmodule : mac_mult_seq
`default_nettype wire

// File: tb/tb_mac_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_mult_seq
// Description : Self-checking bench for mac_mult_seq (2x2x2 @ 8 bit and
//               3x4x2 @ 16 bit instances) against a matrix-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_mult_seq;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // Instance 0: M=K=N=2, 8-bit elements
    logic        start0;
    logic [7:0]  da0, db0;
    logic [0:0]  ra0, ca0, rb0, cb0, ci0, cak0, cbk0, cj0;
    logic [15:0] p0;
    logic        done0, busy0, sd0;

    // Instance 1: M=3, K=4, N=2, 16-bit elements
    logic        start1;
    logic [15:0] da1, db1;
    logic [1:0]  ra1, ca1, rb1, ci1, cak1, cbk1;
    logic [0:0]  cb1, cj1;
    logic [31:0] p1;
    logic        done1, busy1, sd1;

    mac_mult_seq #(.M(2), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(8)) u_dut0 (
        .clk(clk), .resetn(resetn), .start(start0),
        .data_out_a(da0), .data_out_b(db0),
        .row_addr_a(ra0), .col_addr_a(ca0), .row_addr_b(rb0), .col_addr_b(cb0),
        .product_reg(p0),
        .matrix_a_row_addr_counter_reg(ci0), .matrix_a_col_addr_counter_reg(cak0),
        .matrix_b_row_addr_counter_reg(cbk0), .matrix_b_col_addr_counter_reg(cj0),
        .mult_done_reg(done0), .busy(busy0), .seq_done(sd0)
    );

    mac_mult_seq #(.M(3), .K(4), .N(2), .DATA_WIDTH_INIT_MATRIX(16)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start1),
        .data_out_a(da1), .data_out_b(db1),
        .row_addr_a(ra1), .col_addr_a(ca1), .row_addr_b(rb1), .col_addr_b(cb1),
        .product_reg(p1),
        .matrix_a_row_addr_counter_reg(ci1), .matrix_a_col_addr_counter_reg(cak1),
        .matrix_b_row_addr_counter_reg(cbk1), .matrix_b_col_addr_counter_reg(cj1),
        .mult_done_reg(done1), .busy(busy1), .seq_done(sd1)
    );

    // Synchronous-read operand memories
    logic [7:0]  mem_a0 [0:1][0:1];
    logic [7:0]  mem_b0 [0:1][0:1];
    logic [15:0] mem_a1 [0:3][0:3];
    logic [15:0] mem_b1 [0:3][0:1];

    always @(posedge clk) begin
        da0 <= mem_a0[ra0][ca0];
        db0 <= mem_b0[rb0][cb0];
        da1 <= mem_a1[ra1][ca1];
        db1 <= mem_b1[rb1][cb1];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Per-cycle observations of the selected instance
    logic        obs_done [0:63];
    logic        obs_busy [0:63];
    logic        obs_seq  [0:63];
    logic [31:0] obs_prod [0:63];
    int          obs_ci [0:63], obs_cak [0:63], obs_cbk [0:63], obs_cj [0:63];
    int          obs_ai [0:63], obs_aak [0:63], obs_abk [0:63], obs_aj [0:63];

    longint exp_p[$];
    int     exp_i[$], exp_j[$], exp_k[$];

    function automatic longint ref_mul(input longint a, input longint b, input int w);
        longint one = 1;
        longint r;
`ifdef MAC_MULT_SIGNED_EN
        if (a >= (one <<< (w - 1))) a = a - (one <<< w);
        if (b >= (one <<< (w - 1))) b = b - (one <<< w);
`endif
        r = a * b;
        return r & ((one <<< (2 * w)) - 1);
    endfunction

    // C = A*B enumerated as individual products in (i, j, k) order
    task automatic build_model(input int sel);
        int mm, kk, nn;
        exp_p.delete(); exp_i.delete(); exp_j.delete(); exp_k.delete();
        mm = (sel == 0) ? 2 : 3;
        kk = (sel == 0) ? 2 : 4;
        nn = 2;
        for (int i = 0; i < mm; i++)
            for (int j = 0; j < nn; j++)
                for (int k = 0; k < kk; k++) begin
                    if (sel == 0)
                        exp_p.push_back(ref_mul(longint'(mem_a0[i][k]), longint'(mem_b0[k][j]), 8));
                    else
                        exp_p.push_back(ref_mul(longint'(mem_a1[i][k]), longint'(mem_b1[k][j]), 16));
                    exp_i.push_back(i); exp_j.push_back(j); exp_k.push_back(k);
                end
    endtask

    task automatic fill_random(input int sel);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (sel == 0 && r < 2 && c < 2) begin
                    mem_a0[r][c] = 8'($urandom);
                    mem_b0[r][c] = 8'($urandom);
                end
                if (sel == 1) begin
                    mem_a1[r][c] = 16'($urandom);
                    if (c < 2) mem_b1[r][c] = 16'($urandom);
                end
            end
    endtask

    // Called on a falling edge; samples, then drives inputs for the next rising edge.
    task automatic run_seq(input int sel, input int n_cyc, input int restart_at,
                           input int reset_at, input int start2_at);
        for (int c = 0; c < n_cyc; c++) begin
            if (sel == 0) begin
                obs_done[c] = done0; obs_busy[c] = busy0; obs_seq[c] = sd0;
                obs_prod[c] = 32'(p0);
                obs_ci[c] = int'(ci0); obs_cak[c] = int'(cak0); obs_cbk[c] = int'(cbk0); obs_cj[c] = int'(cj0);
                obs_ai[c] = int'(ra0); obs_aak[c] = int'(ca0); obs_abk[c] = int'(rb0); obs_aj[c] = int'(cb0);
            end else begin
                obs_done[c] = done1; obs_busy[c] = busy1; obs_seq[c] = sd1;
                obs_prod[c] = p1;
                obs_ci[c] = int'(ci1); obs_cak[c] = int'(cak1); obs_cbk[c] = int'(cbk1); obs_cj[c] = int'(cj1);
                obs_ai[c] = int'(ra1); obs_aak[c] = int'(ca1); obs_abk[c] = int'(rb1); obs_aj[c] = int'(cb1);
            end
            start0 = (sel == 0) && (c == 0 || c == restart_at || c == start2_at);
            start1 = (sel == 1) && (c == 0 || c == restart_at || c == start2_at);
            resetn = (c != reset_at);
            @(negedge clk);
        end
        start0 = 1'b0;
        start1 = 1'b0;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({p0, ci0, cak0, cbk0, cj0, done0, busy0, sd0, ra0, ca0, rb0, cb0} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut0: got %h required 0",
                     {p0, ci0, cak0, cbk0, cj0, done0, busy0, sd0, ra0, ca0, rb0, cb0});
        end
        n_tests++;
        if ({p1, ci1, cak1, cbk1, cj1, done1, busy1, sd1, ra1, ca1, rb1, cb1} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut1: got %h required 0",
                     {p1, ci1, cak1, cbk1, cj1, done1, busy1, sd1, ra1, ca1, rb1, cb1});
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int dir_p [0:7] = '{5, 14, 6, 16, 15, 28, 18, 32};
        int exp_c [0:1][0:1] = '{'{19, 22}, '{43, 50}};
        int c_mat [0:1][0:1] = '{'{-1, -1}, '{-1, -1}};
        int n = 0, nbusy = 0, nseq = 0, acc = 0, e_i, e_j, e_k;
        mem_a0[0][0] = 8'd1; mem_a0[0][1] = 8'd2; mem_a0[1][0] = 8'd3; mem_a0[1][1] = 8'd4;
        mem_b0[0][0] = 8'd5; mem_b0[0][1] = 8'd6; mem_b0[1][0] = 8'd7; mem_b0[1][1] = 8'd8;
        run_seq(0, 14, -1, -1, -1);
        for (int c = 0; c < 14; c++) begin
            n_tests++;
            if (obs_done[c] !== (c >= 3 && c <= 10)) begin
                n_fail++;
                $display("FAIL dir_done_c%0d: got %b required %b", c, obs_done[c], (c >= 3 && c <= 10));
            end
            if (obs_busy[c]) nbusy++;
            if (obs_seq[c]) nseq++;
            if (obs_done[c] && n < 8 && c >= 2) begin
                e_i = n / 4; e_j = (n / 2) % 2; e_k = n % 2;
                n_tests++;
                if (obs_prod[c] !== 32'(dir_p[n]) || obs_ci[c] != e_i || obs_cj[c] != e_j ||
                    obs_cak[c] != e_k || obs_cbk[c] != e_k) begin
                    n_fail++;
                    $display("FAIL dir_prod_%0d: got p=%0d ijk=%0d%0d%0d/%0d required p=%0d ijk=%0d%0d%0d",
                             n, obs_prod[c], obs_ci[c], obs_cj[c], obs_cak[c], obs_cbk[c], dir_p[n], e_i, e_j, e_k);
                end
                n_tests++;
                if (obs_ci[c] != obs_ai[c-2] || obs_cj[c] != obs_aj[c-2] ||
                    obs_cak[c] != obs_aak[c-2] || obs_cbk[c] != obs_abk[c-2]) begin
                    n_fail++;
                    $display("FAIL dir_align_%0d: got %0d%0d%0d%0d required addr %0d%0d%0d%0d", n,
                             obs_ci[c], obs_cj[c], obs_cak[c], obs_cbk[c],
                             obs_ai[c-2], obs_aj[c-2], obs_aak[c-2], obs_abk[c-2]);
                end
                acc = (obs_cbk[c] == 0) ? int'(obs_prod[c]) : acc + int'(obs_prod[c]);
                if (obs_cbk[c] == 1) c_mat[obs_ci[c]][obs_cj[c]] = acc;
                n++;
            end
        end
        n_tests++;
        if (nbusy != 10 || !obs_busy[1] || !obs_busy[10]) begin
            n_fail++;
            $display("FAIL dir_busy: got %0d cycles required 10 (c1..c10)", nbusy);
        end
        n_tests++;
        if (nseq != 1 || obs_seq[11] !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_seq_done: got %0d pulses (c11=%b) required 1 at c11", nseq, obs_seq[11]);
        end
        for (int r = 0; r < 2; r++)
            for (int q = 0; q < 2; q++) begin
                n_tests++;
                if (c_mat[r][q] != exp_c[r][q]) begin
                    n_fail++;
                    $display("FAIL dir_C%0d%0d: got %0d required %0d", r, q, c_mat[r][q], exp_c[r][q]);
                end
            end
    endtask

    task automatic test_width();
        logic [31:0] exp_w;
`ifdef MAC_MULT_SIGNED_EN
        exp_w = 32'h0000FFEB;
`else
        exp_w = 32'h000006EB;
`endif
        for (int r = 0; r < 2; r++)
            for (int q = 0; q < 2; q++) begin
                mem_a0[r][q] = 8'd253;
                mem_b0[r][q] = 8'd7;
            end
        run_seq(0, 12, -1, -1, -1);
        n_tests++;
        if (!obs_done[3] || obs_prod[3] !== exp_w) begin
            n_fail++;
            $display("FAIL width_product: got done=%b p=%h required 1 %h", obs_done[3], obs_prod[3], exp_w);
        end
    endtask

    task automatic test_restart_ignored();
        int n = 0, nseq = 0;
        fill_random(0);
        build_model(0);
        run_seq(0, 16, 5, -1, -1);
        for (int c = 0; c < 16; c++) begin
            if (obs_seq[c]) nseq++;
            if (obs_done[c]) begin
                n_tests++;
                if (n >= exp_p.size() || obs_prod[c] !== 32'(exp_p[n]) || obs_ci[c] != exp_i[n] ||
                    obs_cj[c] != exp_j[n] || obs_cbk[c] != exp_k[n]) begin
                    n_fail++;
                    $display("FAIL restart_prod_%0d: got p=%h ijk=%0d%0d%0d", n, obs_prod[c],
                             obs_ci[c], obs_cj[c], obs_cbk[c]);
                end
                n++;
            end
        end
        n_tests++;
        if (n != 8 || nseq != 1) begin
            n_fail++;
            $display("FAIL restart_count: got %0d products %0d seq_done required 8 and 1", n, nseq);
        end
    endtask

    task automatic test_reset_midrun();
        int n = 0, nbusy = 0;
        fill_random(0);
        build_model(0);
        run_seq(0, 12, -1, 4, -1);
        n_tests++;
        if (obs_done[5] || obs_busy[5] || obs_seq[5] || obs_prod[5] !== '0 ||
            (obs_ci[5] | obs_cak[5] | obs_cbk[5] | obs_cj[5]) != 0 ||
            (obs_ai[5] | obs_aak[5] | obs_abk[5] | obs_aj[5]) != 0) begin
            n_fail++;
            $display("FAIL midreset_zero: got done=%b busy=%b seq=%b p=%h required all 0",
                     obs_done[5], obs_busy[5], obs_seq[5], obs_prod[5]);
        end
        for (int c = 6; c < 12; c++) if (obs_done[c] || obs_busy[c]) n++;
        n_tests++;
        if (n != 0) begin
            n_fail++;
            $display("FAIL midreset_idle: got %0d active cycles required 0", n);
        end
        n = 0;
        run_seq(0, 14, -1, -1, -1);
        for (int c = 0; c < 14; c++) begin
            if (obs_busy[c]) nbusy++;
            if (obs_done[c]) begin
                n_tests++;
                if (n >= exp_p.size() || obs_prod[c] !== 32'(exp_p[n]) || obs_ci[c] != exp_i[n] ||
                    obs_cj[c] != exp_j[n] || obs_cak[c] != exp_k[n]) begin
                    n_fail++;
                    $display("FAIL midreset_rerun_%0d: got p=%h ijk=%0d%0d%0d", n, obs_prod[c],
                             obs_ci[c], obs_cj[c], obs_cak[c]);
                end
                n++;
            end
        end
        n_tests++;
        if (n != 8 || nbusy != 10 || !obs_done[3]) begin
            n_fail++;
            $display("FAIL midreset_rerun_count: got %0d products %0d busy required 8 and 10", n, nbusy);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        fill_random(0);
        build_model(0);
        run_seq(0, 24, -1, -1, 11);
        for (int c = 0; c < 24; c++) begin
            n_tests++;
            if (obs_done[c] !== ((c >= 3 && c <= 10) || (c >= 14 && c <= 21))) begin
                n_fail++;
                $display("FAIL b2b_done_c%0d: got %b", c, obs_done[c]);
            end
            if (obs_done[c]) begin
                n_tests++;
                if (obs_prod[c] !== 32'(exp_p[n % 8]) || obs_ci[c] != exp_i[n % 8] ||
                    obs_cj[c] != exp_j[n % 8] || obs_cbk[c] != exp_k[n % 8]) begin
                    n_fail++;
                    $display("FAIL b2b_prod_%0d: got p=%h ijk=%0d%0d%0d required p=%h ijk=%0d%0d%0d", n,
                             obs_prod[c], obs_ci[c], obs_cj[c], obs_cbk[c],
                             exp_p[n % 8], exp_i[n % 8], exp_j[n % 8], exp_k[n % 8]);
                end
                n++;
            end
        end
        n_tests++;
        if (obs_busy[11] || !obs_busy[12] || !obs_seq[11] || !obs_seq[22]) begin
            n_fail++;
            $display("FAIL b2b_gap: got busy11=%b busy12=%b seq11=%b seq22=%b required 0 1 1 1",
                     obs_busy[11], obs_busy[12], obs_seq[11], obs_seq[22]);
        end
    endtask

    task automatic test_random_3x4x2();
        for (int it = 0; it < 3; it++) begin
            int n = 0, nbusy = 0, nseq = 0;
            fill_random(1);
            build_model(1);
            run_seq(1, 30, -1, -1, -1);
            for (int c = 0; c < 30; c++) begin
                if (obs_busy[c]) nbusy++;
                if (obs_seq[c]) nseq++;
                if (obs_done[c]) begin
                    n_tests++;
                    if (n >= exp_p.size() || c != n + 3 || obs_prod[c] !== 32'(exp_p[n]) ||
                        obs_ci[c] != exp_i[n] || obs_cj[c] != exp_j[n] ||
                        obs_cak[c] != exp_k[n] || obs_cbk[c] != exp_k[n] ||
                        obs_cak[c] != obs_aak[c-2] || obs_ci[c] != obs_ai[c-2] || obs_cj[c] != obs_aj[c-2]) begin
                        n_fail++;
                        $display("FAIL rnd%0d_prod_%0d: got c=%0d p=%h ijk=%0d%0d%0d/%0d", it, n, c,
                                 obs_prod[c], obs_ci[c], obs_cj[c], obs_cak[c], obs_cbk[c]);
                    end
                    n++;
                end
            end
            n_tests++;
            if (n != 24 || nbusy != 26 || nseq != 1 || !obs_seq[27]) begin
                n_fail++;
                $display("FAIL rnd%0d_count: got %0d products %0d busy %0d seq required 24 26 1",
                         it, n, nbusy, nseq);
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (r < 2 && c < 2) begin mem_a0[r][c] = '0; mem_b0[r][c] = '0; end
                mem_a1[r][c] = '0;
                if (c < 2) mem_b1[r][c] = '0;
            end
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_width();
        test_restart_ignored();
        test_reset_midrun();
        test_back_to_back();
        test_random_3x4x2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mac_mult_seq
`default_nettype wire
